// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write slave among NUM_M masters.
// A grant is held for a whole burst: AW, then all W beats, then the B response.
module axi4_wr_arbiter #(
  parameter int unsigned NUM_M      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_M-1:0]              m_awvalid,
  output logic [NUM_M-1:0]              m_awready,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   m_awaddr,
  input  logic [NUM_M*8-1:0]            m_awlen,
  input  logic [NUM_M*3-1:0]            m_awsize,
  input  logic [NUM_M*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_M-1:0]              m_wvalid,
  input  logic [NUM_M-1:0]              m_wlast,
  output logic [NUM_M-1:0]              m_wready,
  output logic [NUM_M-1:0]              m_bvalid,
  output logic [NUM_M*2-1:0]            m_bresp,
  input  logic [NUM_M-1:0]              m_bready,
  output logic                          s_awvalid,
  output logic [ADDR_WIDTH-1:0]         s_awaddr,
  output logic [7:0]                    s_awlen,
  output logic [2:0]                    s_awsize,
  input  logic                          s_awready,
  output logic                          s_wvalid,
  output logic [DATA_WIDTH-1:0]         s_wdata,
  output logic                          s_wlast,
  input  logic                          s_wready,
  input  logic                          s_bvalid,
  input  logic [1:0]                    s_bresp,
  output logic                          s_bready,
  output logic [$clog2(NUM_M)-1:0]      grant_id,
  output logic                          busy
);

  localparam int unsigned IdW = $clog2(NUM_M);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]     len_q, len_d;

  logic [ADDR_WIDTH-1:0] awaddr_a [NUM_M];
  logic [7:0]            awlen_a  [NUM_M];
  logic [2:0]            awsize_a [NUM_M];
  logic [DATA_WIDTH-1:0] wdata_a  [NUM_M];
  logic [1:0]            bresp_a  [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_slice
    assign awaddr_a[i]       = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign awlen_a[i]        = m_awlen[i*8 +: 8];
    assign awsize_a[i]       = m_awsize[i*3 +: 3];
    assign wdata_a[i]        = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign m_bresp[i*2 +: 2] = bresp_a[i];
  end

  // First requester at or after rr_ptr, wrapping; depends on m_awvalid only.
  logic [IdW-1:0] pick;
  logic [IdW-1:0] idx;
  logic           any_req;

  always_comb begin
    pick    = rr_ptr_q;
    idx     = rr_ptr_q;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      idx = IdW'((32'(rr_ptr_q) + k) % NUM_M);
      if (!any_req && m_awvalid[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = pick;
          state_d = StAw;
        end
      end
      StAw: begin
        if (s_awvalid && s_awready) begin
          len_d      = awlen_a[grant_q];
          beat_cnt_d = 8'd0;
          state_d    = StW;
        end
      end
      StW: begin
        if (s_wvalid && s_wready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (s_wlast) state_d = StB;
        end
      end
      StB: begin
        if (s_bvalid && s_bready) begin
          rr_ptr_d = IdW'((32'(grant_q) + 32'd1) % NUM_M);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 8'd0;
      len_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
    end
  end

  // Handshake signals are gated by the registered state, so reset kills them at once.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    for (int unsigned k = 0; k < NUM_M; k++) bresp_a[k] = 2'b00;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    s_awaddr  = awaddr_a[grant_q];
    s_awlen   = awlen_a[grant_q];
    s_awsize  = awsize_a[grant_q];
    s_wdata   = wdata_a[grant_q];
    unique case (state_q)
      StAw: begin
        s_awvalid          = m_awvalid[grant_q];
        m_awready[grant_q] = s_awready;
      end
      StW: begin
        s_wvalid          = m_wvalid[grant_q];
        // Beat count terminates the burst even when the master never sends WLAST.
        s_wlast           = m_wlast[grant_q] | (beat_cnt_q == len_q);
        m_wready[grant_q] = s_wready;
      end
      StB: begin
        m_bvalid[grant_q] = s_bvalid;
        bresp_a[grant_q]  = s_bresp;
        s_bready          = m_bready[grant_q];
      end
      default: ;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Scoreboard bench for axi4_wr_arbiter: stimulus pushes expected AW/W/B events,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_axi4_wr_arbiter;

  logic        ACLK;
  logic        ARESET;
  logic [1:0]  m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [15:0] m_awlen;
  logic [5:0]  m_awsize;
  logic [63:0] m_wdata;
  logic [1:0]  m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [3:0]  m_bresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [15:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [31:0] s_wdata;
  logic [1:0]  s_bresp;
  logic [0:0]  grant_id;
  logic        busy;

  logic        awvalid_a [2];
  logic [15:0] awaddr_a  [2];
  logic [7:0]  awlen_a   [2];
  logic        wvalid_a  [2];
  logic [31:0] wdata_a   [2];
  logic        wlast_a   [2];
  logic        bready_a  [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      m_awvalid[i]         = awvalid_a[i];
      m_awaddr[i*16 +: 16] = awaddr_a[i];
      m_awlen[i*8 +: 8]    = awlen_a[i];
      m_awsize[i*3 +: 3]   = 3'd2;
      m_wvalid[i]          = wvalid_a[i];
      m_wdata[i*32 +: 32]  = wdata_a[i];
      m_wlast[i]           = wlast_a[i];
      m_bready[i]          = bready_a[i];
    end
  end

  axi4_wr_arbiter #(.NUM_M(2), .DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_wdata(m_wdata),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awready(s_awready), .s_wvalid(s_wvalid),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .grant_id(grant_id), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Memory-backed slave: always ready, SLVERR for addresses at or above 0x1000.
  logic [31:0] mem [1024];
  logic [13:0] wr_ptr;
  logic        wr_err;
  int          wr_count;

  assign s_awready = 1'b1;
  assign s_wready  = 1'b1;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_bvalid <= 1'b0;
      s_bresp  <= 2'b00;
    end else begin
      if (s_awvalid && s_awready) begin
        wr_ptr <= s_awaddr[15:2];
        wr_err <= (s_awaddr >= 16'h1000);
      end
      if (s_wvalid && s_wready) begin
        if (!wr_err) mem[wr_ptr[9:0]] <= s_wdata;
        wr_ptr   <= wr_ptr + 14'd1;
        wr_count <= wr_count + 1;
        if (s_wlast) begin
          s_bvalid <= 1'b1;
          s_bresp  <= wr_err ? 2'b10 : 2'b00;
        end
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
    end
  end

  typedef struct { int gid; logic [15:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;
  typedef struct { int m; logic [1:0] resp; } b_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  b_t  exp_b[$];

  int vectors;
  int miscompares;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic push_aw(input int g, input logic [15:0] a, input logic [7:0] l);
    aw_t e;
    e.gid = g; e.addr = a; e.len = l;
    exp_aw.push_back(e);
  endtask

  task automatic push_w(input logic [31:0] d, input logic l);
    w_t e;
    e.data = d; e.last = l;
    exp_w.push_back(e);
  endtask

  task automatic push_b(input int m, input logic [1:0] r);
    b_t e;
    e.m = m; e.resp = r;
    exp_b.push_back(e);
  endtask

  task automatic monitor_loop();
    aw_t a;
    w_t  w;
    b_t  b;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (s_awvalid && s_awready) begin
          if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else begin
            a = exp_aw.pop_front();
            chk("aw_grant_id", 64'(grant_id), 64'(a.gid));
            chk("aw_addr", 64'(s_awaddr), 64'(a.addr));
            chk("aw_len", 64'(s_awlen), 64'(a.len));
            chk("aw_size", 64'(s_awsize), 64'd2);
          end
        end
        if (s_wvalid && s_wready) begin
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else begin
            w = exp_w.pop_front();
            chk("w_data", 64'(s_wdata), 64'(w.data));
            chk("w_last", 64'(s_wlast), 64'(w.last));
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (m_bvalid[i] && m_bready[i]) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else begin
              b = exp_b.pop_front();
              chk("b_master", 64'(i), 64'(b.m));
              chk("b_resp", 64'(m_bresp[i*2 +: 2]), 64'(b.resp));
              chk("b_other_bvalid", 64'(m_bvalid[1-i]), 64'd0);
              chk("b_other_bresp", 64'(m_bresp[(1-i)*2 +: 2]), 64'd0);
            end
          end
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic master_burst(input int m, input logic [15:0] addr, input logic [7:0] len,
                              input logic [31:0] dbase, input bit send_wlast, input bit toggle,
                              input int bdelay, input bit chk_lat);
    int   n;
    int   beat;
    logic tog;
    awvalid_a[m] = 1'b1;
    awaddr_a[m]  = addr;
    awlen_a[m]   = len;
    if (chk_lat) begin
      @(negedge ACLK);
      chk("aw_arb_cycle_idle", 64'(s_awvalid), 64'd0);
    end
    @(negedge ACLK);
    if (chk_lat) chk("aw_one_cycle_latency", 64'(s_awvalid), 64'd1);
    n = 0;
    while (!m_awready[m] && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!m_awready[m]) begin
      fail_now("aw_timeout");
      awvalid_a[m] = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    awvalid_a[m] = 1'b0;
    beat = 0;
    tog  = 1'b1;
    n    = 0;
    while (beat <= int'(len) && n < 200) begin
      wvalid_a[m] = tog;
      wdata_a[m]  = dbase + 32'(beat);
      wlast_a[m]  = send_wlast && (beat == int'(len));
      @(negedge ACLK);
      if (wvalid_a[m] && m_wready[m]) beat++;
      tog = toggle ? ~tog : 1'b1;
      n++;
      @(posedge ACLK); #1;
    end
    wvalid_a[m] = 1'b0;
    wlast_a[m]  = 1'b0;
    if (beat <= int'(len)) fail_now("w_timeout");
    bready_a[m] = (bdelay == 0);
    @(negedge ACLK);
    n = 0;
    while (!m_bvalid[m] && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!m_bvalid[m]) begin
      fail_now("b_timeout");
      bready_a[m] = 1'b0;
      return;
    end
    if (bdelay > 0) begin
      for (int d = 0; d < bdelay; d++) begin
        if (d > 0) @(negedge ACLK);
        chk("bhold_busy", 64'(busy), 64'd1);
        chk("bhold_bvalid", 64'(m_bvalid[m]), 64'd1);
        chk("bhold_no_awready", 64'(m_awready), 64'd0);
      end
      @(posedge ACLK); #1;
      bready_a[m] = 1'b1;
      @(negedge ACLK);
      chk("b_release_bvalid", 64'(m_bvalid[m]), 64'd1);
    end
    @(posedge ACLK); #1;
    bready_a[m] = 1'b0;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < 2; i++) begin
      awvalid_a[i] = 1'b0; awaddr_a[i] = '0; awlen_a[i] = '0;
      wvalid_a[i]  = 1'b0; wdata_a[i]  = '0; wlast_a[i] = 1'b0;
      bready_a[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    clear_masters();
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "simulation timeout");
  end

  bit t1_done, t2_done, bad, seen;
  int gap, wc0, n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    wr_count    = 0;
    ARESET      = 1'b1;
    clear_masters();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("rst_m_awready", 64'(m_awready), 64'd0);
    chk("rst_s_wvalid", 64'(s_wvalid), 64'd0);
    chk("rst_m_bvalid", 64'(m_bvalid), 64'd0);
    fork monitor_loop(); join_none
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // 1: single master, 4-beat burst
    push_aw(0, 16'h0010, 8'd3);
    for (int i = 0; i < 4; i++) push_w(32'hA0 + 32'(i), i == 3);
    push_b(0, 2'b00);
    fork
      begin
        master_burst(0, 16'h0010, 8'd3, 32'hA0, 1'b1, 1'b0, 0, 1'b1);
        t1_done = 1'b1;
      end
      begin
        bad = 1'b0;
        while (!t1_done) begin
          @(negedge ACLK);
          if (m_awready[1]) bad = 1'b1;
        end
      end
    join
    chk("t1_m1_awready_never", 64'(bad), 64'd0);
    chk("t1_grant_id", 64'(grant_id), 64'd0);
    for (int i = 0; i < 4; i++) chk("t1_mem", 64'(mem[4+i]), 64'(32'hA0 + 32'(i)));

    // 2: both masters request continuously from reset
    do_reset();
    push_aw(0, 16'h0020, 8'd0); push_w(32'hD0, 1'b1); push_b(0, 2'b00);
    push_aw(1, 16'h0030, 8'd0); push_w(32'hE0, 1'b1); push_b(1, 2'b00);
    push_aw(0, 16'h0024, 8'd0); push_w(32'hD1, 1'b1); push_b(0, 2'b00);
    push_aw(1, 16'h0034, 8'd0); push_w(32'hE1, 1'b1); push_b(1, 2'b00);
    fork
      begin
        fork
          begin
            master_burst(0, 16'h0020, 8'd0, 32'hD0, 1'b1, 1'b0, 0, 1'b0);
            master_burst(0, 16'h0024, 8'd0, 32'hD1, 1'b1, 1'b0, 0, 1'b0);
          end
          begin
            master_burst(1, 16'h0030, 8'd0, 32'hE0, 1'b1, 1'b0, 0, 1'b0);
            master_burst(1, 16'h0034, 8'd0, 32'hE1, 1'b1, 1'b0, 0, 1'b0);
          end
        join
        t2_done = 1'b1;
      end
      begin
        seen = 1'b0;
        gap  = 0;
        while (!t2_done) begin
          @(negedge ACLK);
          if (busy) begin
            if (seen && gap > 0) chk("t2_bubble_cycles", 64'(gap), 64'd1);
            seen = 1'b1;
            gap  = 0;
          end else if (seen) gap++;
        end
      end
    join

    // 3: SLVERR routed to M1 only
    push_aw(1, 16'h1000, 8'd0); push_w(32'h55, 1'b1); push_b(1, 2'b10);
    master_burst(1, 16'h1000, 8'd0, 32'h55, 1'b1, 1'b0, 0, 1'b0);

    // 4: M0 8 beats with gappy WVALID and held-off BREADY; M1 waits
    push_aw(0, 16'h0040, 8'd7);
    for (int i = 0; i < 8; i++) push_w(32'hC0 + 32'(i), i == 7);
    push_b(0, 2'b00);
    push_aw(1, 16'h0100, 8'd0); push_w(32'hB0, 1'b1); push_b(1, 2'b00);
    fork
      master_burst(0, 16'h0040, 8'd7, 32'hC0, 1'b1, 1'b1, 5, 1'b0);
      master_burst(1, 16'h0100, 8'd0, 32'hB0, 1'b1, 1'b0, 0, 1'b0);
    join
    for (int i = 0; i < 8; i++) chk("t4_mem", 64'(mem[16+i]), 64'(32'hC0 + 32'(i)));

    // 5: WLAST never driven; beat count ends the burst
    push_aw(0, 16'h0080, 8'd1);
    push_w(32'hF0, 1'b0); push_w(32'hF1, 1'b1);
    push_b(0, 2'b00);
    wc0 = wr_count;
    master_burst(0, 16'h0080, 8'd1, 32'hF0, 1'b0, 1'b0, 0, 1'b0);
    chk("t5_slave_writes", 64'(wr_count - wc0), 64'd2);
    chk("t5_idle_after", 64'(busy), 64'd0);

    // 6: reset during beat 3 of a LEN=7 burst
    push_aw(0, 16'h0200, 8'd7);
    push_w(32'h90, 1'b0); push_w(32'h91, 1'b0);
    awvalid_a[0] = 1'b1; awaddr_a[0] = 16'h0200; awlen_a[0] = 8'd7;
    n = 0;
    @(negedge ACLK);
    while (!m_awready[0] && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!m_awready[0]) fail_now("t6_aw_timeout");
    @(posedge ACLK); #1;
    awvalid_a[0] = 1'b0;
    wvalid_a[0]  = 1'b1;
    wdata_a[0]   = 32'h90;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    wdata_a[0] = 32'h91;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    wdata_a[0] = 32'h92;
    #2;
    ARESET = 1'b1;
    #1;
    chk("t6_rst_s_wvalid", 64'(s_wvalid), 64'd0);
    chk("t6_rst_m_wready", 64'(m_wready), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_grant_id", 64'(grant_id), 64'd0);
    clear_masters();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    push_aw(0, 16'h0300, 8'd0); push_w(32'h70, 1'b1); push_b(0, 2'b00);
    push_aw(1, 16'h0310, 8'd0); push_w(32'h71, 1'b1); push_b(1, 2'b00);
    fork
      master_burst(0, 16'h0300, 8'd0, 32'h70, 1'b1, 1'b0, 0, 1'b0);
      master_burst(1, 16'h0310, 8'd0, 32'h71, 1'b1, 1'b0, 0, 1'b0);
    join

    repeat (3) @(posedge ACLK);
    chk("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_drained", 64'(exp_w.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
